// File: rtl/synapse_mem_pkg.sv
// Shared types and constants for the synaptic weight store.
package synapse_mem_pkg;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_RESP
    } rd_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/synapse_weight_ram.sv
// Weight array: one byte-enabled write port and one registered read port.
// The array itself carries no reset so it maps onto block RAM.
module synapse_weight_ram #(
    parameter int DEPTH  = 72401,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [WIDTH/8-1:0]   i_wbe,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_W-1:0]    i_raddr,
    output logic [WIDTH-1:0]     o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Lane-wise write plus registered read; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < WIDTH / 8; b++) begin
                if (i_wbe[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/synapse_weight_mem_axil.sv
// AXI4-Lite synaptic weight store with a priority core read port.
// Host reads and core reads share the RAM read port; the core wins unless a
// host read has been starved for STARVE_LIMIT cycles.
module synapse_weight_mem_axil
    import synapse_mem_pkg::*;
#(
    parameter int NUM_SYNAPSES = 72401,
    parameter int WEIGHT_W     = 16,
    parameter int AXI_ADDR_W   = 32,
    parameter int STARVE_LIMIT = 8,
    localparam int IDX_W       = $clog2(NUM_SYNAPSES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  core_rd_en,
    input  logic [IDX_W-1:0]      core_rd_addr,
    output logic                  core_rd_ready,
    output logic [WEIGHT_W-1:0]   core_rd_data,
    output logic                  core_rd_valid
);

    localparam int NB    = WEIGHT_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AXI_ADDR_W-3:0] AXI_IDX_LIMIT  = (AXI_ADDR_W-2)'(NUM_SYNAPSES);
    localparam logic [IDX_W:0]        CORE_IDX_LIMIT = (IDX_W+1)'(NUM_SYNAPSES);
    localparam logic [CNT_W-1:0]      STARVE_MAX     = CNT_W'(STARVE_LIMIT);

    wr_state_t r_wrState, w_wrNext;
    rd_state_t r_rdState, w_rdNext;

    logic                r_alive;
    logic                r_awHeld, r_wHeld, r_awInRange;
    logic [IDX_W-1:0]    r_awIdx;
    logic [WEIGHT_W-1:0] r_wData;
    logic [NB-1:0]       r_wStrb;
    logic [1:0]          r_bresp;

    logic                r_arInRange, r_issued;
    logic [IDX_W-1:0]    r_arIdx;
    logic [CNT_W-1:0]    r_starveCnt;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;
    logic                r_coreValid, r_coreInRange;

    logic                w_commit, w_awHs, w_wHs, w_arHs;
    logic                w_awInRange, w_arInRange, w_coreInRange;
    logic                w_axiWant, w_force, w_axiGrant, w_coreAccept;
    logic                w_ramRe;
    logic [IDX_W-1:0]    w_ramRaddr;
    logic [WEIGHT_W-1:0] w_ramQ;
    logic                w_unusedBits;

    assign w_awInRange   = s_axi_awaddr[AXI_ADDR_W-1:2] < AXI_IDX_LIMIT;
    assign w_arInRange   = s_axi_araddr[AXI_ADDR_W-1:2] < AXI_IDX_LIMIT;
    assign w_coreInRange = {1'b0, core_rd_addr} < CORE_IDX_LIMIT;
    assign w_unusedBits  = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata, s_axi_wstrb};

    // Ready outputs stay low until the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_alive <= 1'b0;
        else     r_alive <= 1'b1;
    end

    assign s_axi_awready = r_alive && (r_wrState == WR_IDLE) && !r_awHeld;
    assign s_axi_wready  = r_alive && (r_wrState == WR_IDLE) && !r_wHeld;
    assign s_axi_arready = r_alive && (r_rdState == RD_IDLE);
    assign s_axi_bvalid  = (r_wrState == WR_RESP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = (r_rdState == RD_RESP);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    assign w_awHs = s_axi_awvalid && s_axi_awready;
    assign w_wHs  = s_axi_wvalid && s_axi_wready;
    assign w_arHs = s_axi_arvalid && s_axi_arready;

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wrState <= WR_IDLE;
        else     r_wrState <= w_wrNext;
    end

    // Write FSM: commit once both halves are held, then wait for bready.
    always_comb begin
        w_wrNext = r_wrState;
        w_commit = 1'b0;
        case (r_wrState)
            WR_IDLE: begin
                if (r_awHeld && r_wHeld) begin
                    w_commit = 1'b1;
                    w_wrNext = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) w_wrNext = WR_IDLE;
            end
            default: w_wrNext = WR_IDLE;
        endcase
    end

    // Capture AW and W independently and record the write response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awHeld    <= 1'b0;
            r_wHeld     <= 1'b0;
            r_awInRange <= 1'b0;
            r_awIdx     <= '0;
            r_wData     <= '0;
            r_wStrb     <= '0;
            r_bresp     <= AXI_RESP_OKAY;
        end else begin
            if (w_awHs) begin
                r_awHeld    <= 1'b1;
                r_awIdx     <= s_axi_awaddr[IDX_W+1:2];
                r_awInRange <= w_awInRange;
            end
            if (w_wHs) begin
                r_wHeld <= 1'b1;
                r_wData <= s_axi_wdata[WEIGHT_W-1:0];
                r_wStrb <= s_axi_wstrb[NB-1:0];
            end
            if (w_commit) begin
                r_bresp <= r_awInRange ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
            if ((r_wrState == WR_RESP) && s_axi_bready) begin
                r_awHeld <= 1'b0;
                r_wHeld  <= 1'b0;
            end
        end
    end

    // Arbiter: core first, a host read is forced once it has waited long enough.
    assign w_axiWant     = (r_rdState == RD_WAIT) && !r_issued && r_arInRange;
    assign w_force       = w_axiWant && (r_starveCnt == STARVE_MAX);
    assign w_axiGrant    = w_axiWant && (!core_rd_en || w_force);
    assign core_rd_ready = !w_force;
    assign w_coreAccept  = core_rd_en && core_rd_ready;
    assign w_ramRe       = w_axiGrant || (w_coreAccept && w_coreInRange);
    assign w_ramRaddr    = w_axiGrant ? r_arIdx : core_rd_addr;

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdState <= RD_IDLE;
        else     r_rdState <= w_rdNext;
    end

    // Read FSM: wait for the RAM access plus its output register, then respond.
    always_comb begin
        w_rdNext = r_rdState;
        case (r_rdState)
            RD_IDLE: if (w_arHs)       w_rdNext = RD_WAIT;
            RD_WAIT: if (r_issued)     w_rdNext = RD_RESP;
            RD_RESP: if (s_axi_rready) w_rdNext = RD_IDLE;
            default: w_rdNext = RD_IDLE;
        endcase
    end

    // Read datapath, starvation counter and core valid tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arIdx       <= '0;
            r_arInRange   <= 1'b0;
            r_issued      <= 1'b0;
            r_starveCnt   <= '0;
            r_rdata       <= '0;
            r_rresp       <= AXI_RESP_OKAY;
            r_coreValid   <= 1'b0;
            r_coreInRange <= 1'b0;
        end else begin
            if (w_arHs) begin
                r_arIdx     <= s_axi_araddr[IDX_W+1:2];
                r_arInRange <= w_arInRange;
                r_issued    <= 1'b0;
            end
            if ((r_rdState == RD_WAIT) && !r_issued && (!r_arInRange || w_axiGrant)) begin
                r_issued <= 1'b1;
            end
            if ((r_rdState == RD_WAIT) && r_issued) begin
                r_rdata <= r_arInRange ? 32'(w_ramQ) : 32'd0;
                r_rresp <= r_arInRange ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
            if (w_axiGrant) begin
                r_starveCnt <= '0;
            end else if (w_axiWant && core_rd_en) begin
                r_starveCnt <= r_starveCnt + CNT_W'(1);
            end
            r_coreValid   <= w_coreAccept;
            r_coreInRange <= w_coreInRange;
        end
    end

    assign core_rd_valid = r_coreValid;
    assign core_rd_data  = (r_coreValid && r_coreInRange) ? w_ramQ : '0;

    synapse_weight_ram #(
        .DEPTH (NUM_SYNAPSES),
        .WIDTH (WEIGHT_W),
        .ADDR_W(IDX_W)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_commit && r_awInRange),
        .i_wbe  (r_wStrb),
        .i_waddr(r_awIdx),
        .i_wdata(r_wData),
        .i_re   (w_ramRe),
        .i_raddr(w_ramRaddr),
        .o_rdata(w_ramQ)
    );

endmodule

// File: tb/tb_synapse_weight_mem_axil.sv
// Directed self-checking bench for synapse_weight_mem_axil (default parameters).
module tb_synapse_weight_mem_axil;
    import synapse_mem_pkg::*;

    localparam int NUM = 72401;
    localparam int IW  = $clog2(NUM);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready = 1'b0;
    logic        core_rd_en = 1'b0;
    logic [IW-1:0] core_rd_addr = '0;
    logic        core_rd_ready;
    logic [15:0] core_rd_data;
    logic        core_rd_valid;

    int checkCount = 0;
    int errorCount = 0;

    synapse_weight_mem_axil dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr), .core_rd_ready(core_rd_ready),
        .core_rd_data(core_rd_data), .core_rd_valid(core_rd_valid)
    );

    always #5 clk = ~clk;

    // Watchdog so a stuck handshake still terminates the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Full AXI write; W leads AW by wLead cycles when wLead > 0.
    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int wLead, output logic [1:0] resp);
        bit awDone, wDone, awHs, wHs;
        int cyc;
        awDone = 0; wDone = 0; cyc = 0;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_wvalid = 1'b1; s_axi_awvalid = (wLead == 0);
        while (!(awDone && wDone) && cyc < 50) begin
            awHs = s_axi_awvalid && s_axi_awready;
            wHs  = s_axi_wvalid && s_axi_wready;
            @(posedge clk); #1; cyc++;
            if (awHs) begin awDone = 1; s_axi_awvalid = 1'b0; end
            if (wHs)  begin wDone = 1;  s_axi_wvalid = 1'b0; end
            if (cyc == wLead && !awDone) s_axi_awvalid = 1'b1;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        checkOutput("wr_handshakes", {30'd0, awDone, wDone}, 32'd3);
        checkOutput("bvalid_before_commit", s_axi_bvalid, 1'b0);
        @(posedge clk); #1;
        checkOutput("bvalid_latency", s_axi_bvalid, 1'b1);
        resp = s_axi_bresp;
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        checkOutput("bvalid_drop", s_axi_bvalid, 1'b0);
    endtask

    // Full AXI read; lat counts edges from the AR handshake to rvalid.
    task automatic axiRead(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int cyc;
        cyc = 0;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        lat = 0;
        while (!s_axi_rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
        data = s_axi_rdata; resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
        checkOutput("rvalid_drop", s_axi_rvalid, 1'b0);
    endtask

    task automatic coreRead(input string tag, input int idx, input logic [15:0] expected);
        core_rd_en = 1'b1; core_rd_addr = IW'(idx);
        checkOutput({tag, "_ready"}, core_rd_ready, 1'b1);
        @(posedge clk); #1;
        core_rd_en = 1'b0;
        checkOutput({tag, "_valid"}, core_rd_valid, 1'b1);
        checkOutput({tag, "_data"}, core_rd_data, expected);
    endtask

    task automatic applyStimulus();
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;
        logic [15:0] coreVals [4];
        coreVals = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};

        // Reset state
        #12;
        checkOutput("rst_awready", s_axi_awready, 0);
        checkOutput("rst_wready", s_axi_wready, 0);
        checkOutput("rst_arready", s_axi_arready, 0);
        checkOutput("rst_bvalid", s_axi_bvalid, 0);
        checkOutput("rst_bresp", s_axi_bresp, 0);
        checkOutput("rst_rvalid", s_axi_rvalid, 0);
        checkOutput("rst_rdata", s_axi_rdata, 0);
        checkOutput("rst_rresp", s_axi_rresp, 0);
        checkOutput("rst_core_valid", core_rd_valid, 0);
        checkOutput("rst_core_data", core_rd_data, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_awready", s_axi_awready, 1);
        checkOutput("post_rst_wready", s_axi_wready, 1);
        checkOutput("post_rst_arready", s_axi_arready, 1);

        // Write then read
        axiWrite(32'(5 << 2), 32'h0000_ABCD, 4'b0011, 0, resp);
        checkOutput("wr5_bresp", resp, AXI_RESP_OKAY);
        axiRead(32'(5 << 2), data, resp, lat);
        checkOutput("rd5_data", data, 32'h0000_ABCD);
        checkOutput("rd5_rresp", resp, AXI_RESP_OKAY);
        checkOutput("rd5_latency", lat, 2);
        coreRead("core5", 5, 16'hABCD);

        // Zero strobe and upper-lane-only strobe leave the word alone
        axiWrite(32'(5 << 2), 32'hFFFF_FFFF, 4'b0000, 0, resp);
        checkOutput("strb0_bresp", resp, AXI_RESP_OKAY);
        axiWrite(32'(5 << 2), 32'hFFFF_FFFF, 4'b1100, 0, resp);
        coreRead("strb_upper", 5, 16'hABCD);

        // Data-first ordering and byte strobe
        axiWrite(32'(7 << 2), 32'h0000_1234, 4'b0011, 3, resp);
        checkOutput("wr7_bresp", resp, AXI_RESP_OKAY);
        axiWrite(32'(7 << 2), 32'h0000_00FF, 4'b0010, 0, resp);
        axiRead(32'(7 << 2), data, resp, lat);
        checkOutput("rd7_strb_data", data, 32'h0000_0034);

        // Out of range
        axiWrite(32'((NUM - 1) << 2), 32'h0000_7777, 4'b0011, 0, resp);
        axiWrite(32'(NUM << 2), 32'h0000_BEEF, 4'b0011, 0, resp);
        checkOutput("oor_bresp", resp, AXI_RESP_SLVERR);
        axiRead(32'((NUM - 1) << 2), data, resp, lat);
        checkOutput("oor_neighbour_intact", data, 32'h0000_7777);
        axiRead(32'(NUM << 2), data, resp, lat);
        checkOutput("oor_rdata", data, 0);
        checkOutput("oor_rresp", resp, AXI_RESP_SLVERR);
        checkOutput("oor_latency", lat, 2);
        coreRead("core_oor", NUM, 16'h0000);

        // Starvation: core hammers the port while a host read waits
        for (int k = 0; k < 4; k++) axiWrite(32'((10 + k) << 2), 32'(coreVals[k]), 4'b0011, 0, resp);
        axiWrite(32'(20 << 2), 32'h0000_2020, 4'b0011, 0, resp);
        fork
            begin
                int notReady;
                logic rdyBefore;
                notReady = 0;
                for (int i = 0; i < 20; i++) begin
                    core_rd_en = 1'b1;
                    core_rd_addr = IW'(10 + (i % 4));
                    rdyBefore = core_rd_ready;
                    if (!rdyBefore) notReady++;
                    @(posedge clk); #1;
                    checkOutput("starve_core_valid", core_rd_valid, rdyBefore);
                    if (rdyBefore) checkOutput("starve_core_data", core_rd_data, coreVals[i % 4]);
                end
                core_rd_en = 1'b0;
                checkOutput("starve_notready_cycles", notReady, 1);
            end
            begin
                logic [31:0] sData;
                logic [1:0]  sResp;
                int          sLat;
                axiRead(32'(20 << 2), sData, sResp, sLat);
                checkOutput("starve_axi_data", sData, 32'h0000_2020);
                checkOutput("starve_axi_rresp", sResp, AXI_RESP_OKAY);
                checkOutput("starve_axi_lat_bounded", (sLat >= 10 && sLat <= 11), 1);
            end
        join

        // Same-edge collision: core sees old data, then new
        axiWrite(32'(3 << 2), 32'h0000_1111, 4'b0011, 0, resp);
        s_axi_awaddr = 32'(3 << 2); s_axi_wdata = 32'h0000_5555; s_axi_wstrb = 4'b0011;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        core_rd_en = 1'b1; core_rd_addr = IW'(3);
        @(posedge clk); #1;
        checkOutput("coll_bvalid", s_axi_bvalid, 1);
        checkOutput("coll_old_data", core_rd_data, 16'h1111);
        @(posedge clk); #1;
        checkOutput("coll_new_data", core_rd_data, 16'h5555);
        core_rd_en = 1'b0; s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;

        // Reset while a write response is pending
        axiWrite(32'(30 << 2), 32'h0000_3030, 4'b0011, 0, resp);
        s_axi_awaddr = 32'(31 << 2); s_axi_wdata = 32'h0000_3131; s_axi_wstrb = 4'b0011;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_bvalid_pending", s_axi_bvalid, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_bvalid_dropped", s_axi_bvalid, 0);
        checkOutput("midrst_awready", s_axi_awready, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_awready_back", s_axi_awready, 1);
        checkOutput("midrst_bvalid_not_replayed", s_axi_bvalid, 0);
        axiWrite(32'(32 << 2), 32'h0000_3232, 4'b0011, 0, resp);
        checkOutput("midrst_new_bresp", resp, AXI_RESP_OKAY);
        axiRead(32'(30 << 2), data, resp, lat);
        checkOutput("midrst_old_intact", data, 32'h0000_3030);
        axiRead(32'(32 << 2), data, resp, lat);
        checkOutput("midrst_new_data", data, 32'h0000_3232);
        coreRead("midrst_committed", 31, 16'h3131);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
